serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor computing D = A − B − Bin one bit per clock, LSB first, using a registered borrow flip-flop. It is the inverse-direction companion to the combinational adder datapath. It trades area for latency, and exchanges operands and results with neighbouring blocks through valid/ready handshakes on both sides.

## Interface
- WIDTH, default 4: operand/result width in bits; legal range ≥ 2.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand set A/B/Bin is valid.
- in_ready  output  1  block can accept operands (IDLE only).
- A  input  WIDTH  minuend, unsigned or two's complement.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  result D/Bout(/V) is valid.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference, A − B − Bin mod 2^WIDTH.
- Bout  output  1  borrow out; 1 iff A < B + Bin (unsigned).
- V  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. When in_valid && in_ready, the block:
  - latches A and B into shift registers and Bin into the borrow FF;
  - clears the bit counter and goes to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - full_subtractor consumes A_sh[0], B_sh[0] and borrow;
  - the difference bit shifts into the D register from the MSB side;
  - the borrow FF updates and the operand registers shift right;
  - the counter increments.
  - After the bit with counter == WIDTH−1 is processed, the FSM goes to DONE.
- DONE: out_valid=1 and D/Bout/V are held stable. On out_valid && out_ready the FSM goes to IDLE. in_valid is ignored outside IDLE.
- Arithmetic:
  - Counter width is $clog2(WIDTH), minimum 1.
  - Bout is the final borrow FF value.
  - V = (A[MSB] ≠ B[MSB]) && (D[MSB] ≠ A[MSB]), computed from the latched A/B MSBs.
  - Bin does not enter the V formula; D already includes Bin.
- Reset (rst_n=0 at an edge, any state, including mid-RUN):
  - FSM goes to IDLE; operand, D, borrow and counter registers are set to 0.
  - Outputs after reset: in_ready=1, out_valid=0, D=0, Bout=0, V=0.
  - A partial operation is discarded with no output.

## Timing
- Operand handshake at edge k. Bit i is processed at edge k+1+i. out_valid rises after edge k+WIDTH, giving a latency of WIDTH cycles.
- Output handshake at edge m: out_valid=0 and in_ready=1 from edge m onward. The next operand can be accepted at edge m+1.
- No operand/result overlap. Throughput is one result per WIDTH+2 cycles when out_ready is held high.
- Backpressure: with out_ready=0, DONE holds indefinitely with outputs unchanged.
- in_ready depends only on state. It is never combinationally dependent on out_ready.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - V port and its MSB capture registers exist.
  - V is valid with out_valid and holds through backpressure.
- Undefined: V port, its logic and the MSB capture registers are absent. All other behaviour is identical.

## Structure
- Package serial_sub_pkg contains:
  - the state typedef (enum: IDLE, RUN, DONE);
  - the localparam default width constant SERIAL_SUB_WIDTH_DEF = 4.
- One sub-module, full_subtractor (inputs A, B, Bin; outputs D, Bout):
  - D = A^B^Bin;
  - Bout = (~A&B) | (~(A^B)&Bin).
- It is instantiated once in the datapath.

## Test plan
- WIDTH=4, A=5, B=3, Bin=0 → after 4 cycles out_valid=1, D=4'h2, Bout=0, V=0.
- A=3, B=5, Bin=0 → D=4'hE, Bout=1, V=0.
- A=4'h8, B=4'h1, Bin=0 → D=4'h7, Bout=0, V=1 (signed −8−1 overflow); V absent when the macro is undefined.
- A=0, B=0, Bin=1 → D=4'hF, Bout=1, V=0.
- Backpressure: out_ready=0 for 3 cycles after out_valid:
  - D/Bout stay constant, in_ready=0 and new in_valid is ignored;
  - out_ready=1 → in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 during RUN at bit 2:
  - next cycle in_ready=1, out_valid=0, D=0;
  - a following op A=9, B=2 yields D=4'h7, Bout=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : serial_sub_pkg                                              |
// | Purpose  : Shared types and constants for the bit-serial subtractor.   |
// |            Holds the FSM state encoding and the default operand width. |
// | Optional : SERIAL_SUB_OVF_EN (signed overflow flag V) is handled in    |
// |            the interface and top; nothing here depends on it.          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : serial_subtractor_if                                        |
// | Purpose  : Operand/result handshake bundle for serial_subtractor.      |
// | Signals  : in_valid/in_ready, A, B, Bin   - operand side               |
// |            out_valid/out_ready, D, Bout   - result side                |
// |            V                              - only with SERIAL_SUB_OVF_EN|
// | Modports : master - the neighbour that drives operands, takes results  |
// |            slave  - the subtractor itself                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             V;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, V
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, V
  );
`else
  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout
  );
`endif

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : full_subtractor                                             |
// | Purpose  : One-bit full subtractor, A - B - Bin.                       |
// | Ports    : A, B, Bin (in)  - minuend bit, subtrahend bit, borrow in    |
// |            D, Bout (out)   - difference bit, borrow out               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module full_subtractor (
  input  wire logic A,
  input  wire logic B,
  input  wire logic Bin,
  output logic      D,
  output logic      Bout
);

  assign D    = A ^ B ^ Bin;
  // Borrow when the minuend bit is 0 against a 1, or when the bits are
  // equal and a borrow is already pending.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : serial_subtractor                                           |
// | Purpose  : Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, |
// |            one bit per clock through a single full_subtractor and a    |
// |            registered borrow. Operands enter and results leave through |
// |            valid/ready handshakes; no overlap between the two.         |
// | Ports    : clk   - clock, rising edge                                  |
// |            rst_n - synchronous active-low reset                        |
// |            bus   - serial_subtractor_if.slave (handshakes, A/B/Bin,    |
// |                    D/Bout and V when enabled)                          |
// | Optional : SERIAL_SUB_OVF_EN adds the signed overflow flag V and the   |
// |            operand MSB capture registers behind it.                    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_subtractor_if.slave bus
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_d;
  logic               r_borrow;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_dbit;
  logic               w_bout;

  full_subtractor u_fs (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Bin  (r_borrow),
    .D    (w_dbit),
    .Bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_d         <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh     <= bus.A;
            r_b_sh     <= bus.B;
            r_borrow   <= bus.Bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB; after WIDTH shifts the first
          // (LSB) result bit has walked down to position 0.
          r_d      <= {w_dbit, r_d[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.D         = r_d;
  assign bus.Bout      = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
  // The operand shift registers are consumed during RUN, so the sign bits
  // needed for V are kept aside at operand acceptance.
  if (1) begin : g_ovf
    logic r_a_msb;
    logic r_b_msb;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_a_msb <= 1'b0;
        r_b_msb <= 1'b0;
      end else if ((r_state == IDLE) && bus.in_valid) begin
        r_a_msb <= bus.A[WIDTH-1];
        r_b_msb <= bus.B[WIDTH-1];
      end
    end

    // Overflow only possible when operand signs differ; it happened when
    // the result sign departs from the minuend sign. Bin is already in D.
    assign bus.V = (r_a_msb ^ r_b_msb) & (r_d[WIDTH-1] ^ r_a_msb);
  end : g_ovf
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_serial_subtractor                                        |
// | Purpose  : Self-checking bench for serial_subtractor. Expected results |
// |            come from integer arithmetic and are queued at operand      |
// |            acceptance; a monitor pops them at each result handshake.   |
// | Optional : SERIAL_SUB_OVF_EN also checks the V flag.                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = SERIAL_SUB_WIDTH_DEF;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  exp_t q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer subtraction, unsigned and signed views.
  function automatic exp_t model(input int a, input int b, input int bin);
    exp_t m;
    int diff, sa, sb, sd;
    diff   = a - b - bin;
    m.d    = W'(diff);
    m.bout = (diff < 0);
    sa     = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
    sb     = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
    sd     = sa - sb - bin;
    m.v    = (sd > 2 ** (W - 1) - 1) || (sd < -(2 ** (W - 1)));
    return m;
  endfunction

  // Monitor: a result handshake is pending at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("D", 32'(bus.D), 32'(e.d));
        check("Bout", 32'(bus.Bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
        check("V", 32'(bus.V), 32'(e.v));
`endif
      end
    end
  end

  task automatic do_op(input int a, input int b, input int bin, input int hold);
    int   cyc;
    bit   ok;
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.A         = W'(a);
    bus.B         = W'(b);
    bus.Bin       = bin[0];
    bus.out_ready = (hold == 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin check("in_ready_timeout", 32'd0, 32'd1); bus.in_valid = 1'b0; return; end
    e = model(a, b, bin);
    q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Latency in edges from acceptance to out_valid visible.
    cyc = 0; ok = 0;
    for (int i = 0; i < 3 * W + 10; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; break; end
    end
    if (!ok) begin check("out_valid_timeout", 32'd0, 32'd1); return; end
    check("latency", 32'(cyc), 32'(W));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.A        = W'(~a);
      bus.B        = W'(~b);
      bus.Bin      = ~bin[0];
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_D", 32'(bus.D), 32'(e.d));
      check("bp_Bout", 32'(bus.Bout), 32'(e.bout));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_D", 32'(bus.D), 32'd0);
    check("rst_Bout", 32'(bus.Bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_V", 32'(bus.V), 32'd0);
`endif
    rst_n = 1'b1;

    do_op(5, 3, 0, 0);
    do_op(3, 5, 0, 0);
    do_op(8, 1, 0, 0);
    do_op(0, 0, 1, 0);
    do_op(15, 15, 1, 0);
    do_op(7, 8, 0, 3);

    // Reset while bit 2 would be processed.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = 4'hB; bus.B = 4'h4; bus.Bin = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;       // acceptance edge (DUT idle)
    bus.in_valid = 1'b0;
    @(posedge clk);           // bit 0
    @(posedge clk);           // bit 1
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);           // bit-2 edge sees reset
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_D", 32'(bus.D), 32'd0);
    check("midrst_Bout", 32'(bus.Bout), 32'd0);
    do_op(9, 2, 0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 2 ** W - 1)), int'($urandom_range(0, 2 ** W - 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
